// File: rtl/pixel_plotter.sv
// Pixel sink: buffers (x, y, color) pixels, clips them to the visible area and
// turns them into framebuffer write cycles; also sweeps the framebuffer on a clear request.
module pixel_plotter #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int ADDR_W  = 19,
    parameter int COLOR_W = 1,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [10:0]        in_x,
    input  logic [10:0]        in_y,
    input  logic [COLOR_W-1:0] in_color,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               clear_req,
    input  logic [COLOR_W-1:0] bg_color,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_data,
    output logic               clear_done,
    output logic               busy,
    output logic [15:0]        drop_count
);

    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W     = 22 + COLOR_W;
    localparam int CLR_TOTAL = WIDTH * HEIGHT;

    localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [ADDR_W:0]  CLR_N    = CLR_TOTAL[ADDR_W:0];
    localparam logic [ADDR_W:0]  CLR_ONE  = (ADDR_W + 1)'(1);
    localparam logic [10:0]      X_LIM    = WIDTH[10:0];
    localparam logic [10:0]      Y_LIM    = HEIGHT[10:0];
    localparam logic [21:0]      WIDTH_22 = WIDTH[21:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    state_t state_r;
    state_t state_s;

    logic [ENT_W-1:0]   fifo_mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W:0]     fifo_cnt_r;
    logic               fifo_empty_s;
    logic               fifo_full_s;
    logic               push_s;
    logic               pop_s;
    logic [ENT_W-1:0]   head_s;

    logic               s1_valid_r;
    logic [10:0]        s1_x_r;
    logic [10:0]        s1_y_r;
    logic [COLOR_W-1:0] s1_color_r;
    logic               in_range_s;
    logic [ADDR_W-1:0]  pix_addr_s;

    logic [ADDR_W:0]    clr_cnt_r;
    logic [COLOR_W-1:0] bg_r;
    logic               clr_end_s;
    logic               pipe_empty_s;
    logic               ready_en_r;
    logic               in_ready_s;

    logic               wr_en_r;
    logic [ADDR_W-1:0]  wr_addr_r;
    logic [COLOR_W-1:0] wr_data_r;
    logic               clear_done_r;
    logic               busy_r;
    logic [15:0]        drop_count_r;

    // Handshake and FIFO status decode
    always_comb begin
        fifo_empty_s = (fifo_cnt_r == '0);
        fifo_full_s  = (fifo_cnt_r == FULL_CNT);
        // Refuse pixels in the clear_req cycle and the clear_done cycle so a
        // clear is never interleaved with fresh pixels.
        in_ready_s   = ready_en_r && !fifo_full_s && !clear_req && !clear_done_r &&
                       ((state_r == ST_IDLE) || (state_r == ST_DRAW));
        push_s       = in_valid && in_ready_s;
        pop_s        = !fifo_empty_s && ((state_r == ST_DRAW) || (state_r == ST_DRAIN));
        head_s       = fifo_mem_r[rd_ptr_r];
        pipe_empty_s = fifo_empty_s && !s1_valid_r && !wr_en_r;
        clr_end_s    = (clr_cnt_r == CLR_N);
    end

    // Clip test and linear address for the pixel held in S1
    always_comb begin
        in_range_s = (s1_x_r < X_LIM) && (s1_y_r < Y_LIM);
        pix_addr_s = ADDR_W'(({11'd0, s1_y_r} * WIDTH_22) + {11'd0, s1_x_r});
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clear_req) begin
                    state_s = ST_CLEAR;
                end else if (!fifo_empty_s) begin
                    state_s = ST_DRAW;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRAW: begin
                if (clear_req) begin
                    state_s = ST_DRAIN;
                end else if (pipe_empty_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAW;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty_s) begin
                    state_s = ST_CLEAR;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_CLEAR: begin
                if (clr_end_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register, busy flag and post-reset ready enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            ready_en_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            busy_r     <= (state_s != ST_IDLE);
            ready_en_r <= 1'b1;
        end
    end

    // Input FIFO storage and pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {in_color, in_y, in_x};
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_ONE;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_ONE;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Stage S1: holds the popped pixel for one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_x_r     <= 11'd0;
            s1_y_r     <= 11'd0;
            s1_color_r <= '0;
        end else begin
            s1_valid_r <= pop_s;
            if (pop_s) begin
                s1_x_r     <= head_s[10:0];
                s1_y_r     <= head_s[21:11];
                s1_color_r <= head_s[ENT_W-1:22];
            end
        end
    end

    // Clear sweep counter; background color is captured on entry to CLEAR
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_cnt_r <= '0;
            bg_r      <= '0;
        end else if ((state_r != ST_CLEAR) && (state_s == ST_CLEAR)) begin
            clr_cnt_r <= '0;
            bg_r      <= bg_color;
        end else if ((state_r == ST_CLEAR) && !clr_end_s) begin
            clr_cnt_r <= clr_cnt_r + CLR_ONE;
        end else begin
            clr_cnt_r <= clr_cnt_r;
        end
    end

    // Framebuffer write port, clear completion pulse and drop counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en_r      <= 1'b0;
            wr_addr_r    <= '0;
            wr_data_r    <= '0;
            clear_done_r <= 1'b0;
            drop_count_r <= 16'd0;
        end else begin
            clear_done_r <= (state_r == ST_CLEAR) && clr_end_s;
            if ((state_r == ST_CLEAR) && !clr_end_s) begin
                wr_en_r   <= 1'b1;
                wr_addr_r <= clr_cnt_r[ADDR_W-1:0];
                wr_data_r <= bg_r;
            end else if (s1_valid_r && in_range_s) begin
                wr_en_r   <= 1'b1;
                wr_addr_r <= pix_addr_s;
                wr_data_r <= s1_color_r;
            end else begin
                wr_en_r   <= 1'b0;
            end
            if (s1_valid_r && !in_range_s) begin
                drop_count_r <= drop_count_r + 16'd1;
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign clear_done = clear_done_r;
    assign busy       = busy_r;
    assign drop_count = drop_count_r;

endmodule

// File: tb/tb_pixel_plotter.sv
// Bench for pixel_plotter: a full-size instance for the pixel path and an 8x4
// instance for clear sequences, both checked against write scoreboards.
module tb_pixel_plotter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int b_stalls;

    always @(posedge clk) cyc <= cyc + 1;

    // full-size instance
    logic [10:0] b_x, b_y;
    logic        b_color, b_valid, b_ready, b_clr, b_bg;
    logic        b_wr_en, b_wr_data, b_done, b_busy;
    logic [18:0] b_wr_addr;
    logic [15:0] b_drop;

    // 8x4 instance
    logic [10:0] s_x, s_y;
    logic        s_color, s_valid, s_ready, s_clr, s_bg;
    logic        s_wr_en, s_wr_data, s_done, s_busy;
    logic [4:0]  s_wr_addr;
    logic [15:0] s_drop;

    pixel_plotter dut (
        .clk(clk), .reset(reset), .in_x(b_x), .in_y(b_y), .in_color(b_color),
        .in_valid(b_valid), .in_ready(b_ready), .clear_req(b_clr), .bg_color(b_bg),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .clear_done(b_done), .busy(b_busy), .drop_count(b_drop)
    );

    pixel_plotter #(.WIDTH(8), .HEIGHT(4), .ADDR_W(5), .COLOR_W(1), .DEPTH(4)) dut_small (
        .clk(clk), .reset(reset), .in_x(s_x), .in_y(s_y), .in_color(s_color),
        .in_valid(s_valid), .in_ready(s_ready), .clear_req(s_clr), .bg_color(s_bg),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .clear_done(s_done), .busy(s_busy), .drop_count(s_drop)
    );

    typedef struct { logic [18:0] addr; logic data; } wr_t;
    wr_t bq[$];
    wr_t sq[$];
    wr_t be, se;

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic        c;
        logic        wr;
        logic [18:0] addr;
    } vec_t;
    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // scoreboard for the full-size instance
    always @(negedge clk) begin
        if (reset === 1'b0 && b_wr_en === 1'b1) begin
            if (bq.size() == 0) begin
                tests++; fails++;
                $display("FAIL big_unexpected_write: got addr %0d expected no write", b_wr_addr);
            end else begin
                be = bq.pop_front();
                chk("big_wr_addr", 32'(b_wr_addr), 32'(be.addr));
                chk("big_wr_data", 32'(b_wr_data), 32'(be.data));
            end
        end
    end

    // scoreboard for the 8x4 instance
    always @(negedge clk) begin
        if (reset === 1'b0 && s_wr_en === 1'b1) begin
            if (sq.size() == 0) begin
                tests++; fails++;
                $display("FAIL small_unexpected_write: got addr %0d expected no write", s_wr_addr);
            end else begin
                se = sq.pop_front();
                chk("small_wr_addr", 32'(s_wr_addr), 32'(se.addr));
                chk("small_wr_data", 32'(s_wr_data), 32'(se.data));
            end
        end
    end

    // starts and ends just after a rising edge
    task automatic send_big(input logic [10:0] x, input logic [10:0] y, input logic c);
        bit ok = 1'b0;
        b_x = x; b_y = y; b_color = c; b_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (b_ready) ok = 1'b1;
            else b_stalls++;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL big_send_timeout: got in_ready 0 expected 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic send_small(input logic [10:0] x, input logic [10:0] y, input logic c);
        bit ok = 1'b0;
        s_x = x; s_y = y; s_color = c; s_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL small_send_timeout: got in_ready 0 expected 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_big_idle(input string name);
        bit ok = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (!b_busy && bq.size() == 0) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    // watches a clear from the cycle after clear_req up to clear_done
    task automatic clear_watch(input int repulse, output int nwr, output int rdy_bad, output bit done);
        nwr = 0; rdy_bad = 0; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (s_ready) rdy_bad++;
            if (s_done) begin
                done = 1'b1;
                chk("clear_done_wr_en", 32'(s_wr_en), 32'd0);
                chk("clear_done_busy", 32'(s_busy), 32'd0);
            end else if (s_wr_en) begin
                nwr++;
            end
            s_clr = (repulse != 0) && (nwr == repulse) && !done;
            if (s_clr) s_bg = ~s_bg;
        end
    endtask

    initial begin
        int acc, first, nwr, rb, found, extra;
        bit done;

        vecs[0]  = '{11'd10,   11'd100,  1'b1, 1'b1, 19'd64010};
        vecs[1]  = '{11'd11,   11'd100,  1'b1, 1'b1, 19'd64011};
        vecs[2]  = '{11'd12,   11'd100,  1'b1, 1'b1, 19'd64012};
        vecs[3]  = '{11'd0,    11'd0,    1'b1, 1'b1, 19'd0};
        vecs[4]  = '{11'd639,  11'd0,    1'b0, 1'b1, 19'd639};
        vecs[5]  = '{11'd0,    11'd479,  1'b1, 1'b1, 19'd306560};
        vecs[6]  = '{11'd639,  11'd479,  1'b1, 1'b1, 19'd307199};
        vecs[7]  = '{11'd320,  11'd240,  1'b0, 1'b1, 19'd153920};
        vecs[8]  = '{11'd1,    11'd1,    1'b1, 1'b1, 19'd641};
        vecs[9]  = '{11'd640,  11'd0,    1'b1, 1'b0, 19'd0};
        vecs[10] = '{11'd0,    11'd480,  1'b1, 1'b0, 19'd0};
        vecs[11] = '{11'd2047, 11'd2047, 1'b1, 1'b0, 19'd0};
        vecs[12] = '{11'd5,    11'd5,    1'b1, 1'b1, 19'd3205};

        b_x = 11'd0; b_y = 11'd0; b_color = 1'b0; b_valid = 1'b0; b_clr = 1'b0; b_bg = 1'b0;
        s_x = 11'd0; s_y = 11'd0; s_color = 1'b0; s_valid = 1'b0; s_clr = 1'b0; s_bg = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 32'(b_ready), 32'd0);
        chk("reset_small_in_ready", 32'(s_ready), 32'd0);
        chk("reset_wr_en", 32'(b_wr_en), 32'd0);
        chk("reset_wr_addr", 32'(b_wr_addr), 32'd0);
        chk("reset_wr_data", 32'(b_wr_data), 32'd0);
        chk("reset_busy", 32'(b_busy), 32'd0);
        chk("reset_clear_done", 32'(b_done), 32'd0);
        chk("reset_drop_count", 32'(b_drop), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(b_ready), 32'd1);
        chk("small_ready_after_reset", 32'(s_ready), 32'd1);

        // three back-to-back pixels: latency and consecutive writes
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            bq.push_back('{vecs[i].addr, vecs[i].c});
            send_big(vecs[i].x, vecs[i].y, vecs[i].c);
            if (i == 0) acc = cyc;
        end
        b_valid = 1'b0;
        first = -1;
        for (int k = 0; k < 20 && first < 0; k++) begin
            @(negedge clk);
            if (b_wr_en) first = cyc;
        end
        chk("first_write_latency", 32'(first - acc), 32'd3);
        @(negedge clk); chk("second_write", 32'(b_wr_en), 32'd1);
        @(negedge clk); chk("third_write", 32'(b_wr_en), 32'd1);
        @(negedge clk); chk("write_gap_after_last", 32'(b_wr_en), 32'd0);
        @(posedge clk); #1;
        wait_big_idle("idle_after_three");

        // burst of 6 through a 4-deep FIFO: never stalls
        b_stalls = 0;
        for (int i = 3; i < 9; i++) begin
            bq.push_back('{vecs[i].addr, vecs[i].c});
            send_big(vecs[i].x, vecs[i].y, vecs[i].c);
        end
        b_valid = 1'b0;
        chk("burst_no_stall", 32'(b_stalls), 32'd0);
        wait_big_idle("idle_after_burst");

        // clipping
        extra = 0;
        for (int i = 9; i < 13; i++) begin
            if (vecs[i].wr) bq.push_back('{vecs[i].addr, vecs[i].c});
            else extra++;
            send_big(vecs[i].x, vecs[i].y, vecs[i].c);
        end
        b_valid = 1'b0;
        wait_big_idle("idle_after_clip");
        chk("drop_count", 32'(b_drop), 32'(extra));

        // plain clear with bg 0, plus an ignored clear_req mid-sweep
        for (int i = 0; i < 32; i++) sq.push_back('{19'(i), 1'b0});
        @(negedge clk);
        s_bg = 1'b0; s_clr = 1'b1;
        #1 chk("clear_req_ready_low", 32'(s_ready), 32'd0);
        clear_watch(5, nwr, rb, done);
        s_bg = 1'b0;
        chk("clear_write_count", 32'(nwr), 32'd32);
        chk("clear_ready_low", 32'(rb), 32'd0);
        chk("clear_done_seen", 32'(done), 32'd1);
        @(negedge clk);
        chk("ready_after_clear", 32'(s_ready), 32'd1);
        chk("clear_scoreboard_empty", 32'(sq.size()), 32'd0);
        @(posedge clk); #1;

        // clear requested while three pixels are queued
        sq.push_back('{19'd1, 1'b1});
        sq.push_back('{19'd10, 1'b0});
        sq.push_back('{19'd31, 1'b1});
        for (int i = 0; i < 32; i++) sq.push_back('{19'(i), 1'b1});
        send_small(11'd1, 11'd0, 1'b1);
        send_small(11'd2, 11'd1, 1'b0);
        send_small(11'd7, 11'd3, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);
        s_bg = 1'b1; s_clr = 1'b1;
        #1 chk("drain_req_ready_low", 32'(s_ready), 32'd0);
        clear_watch(0, nwr, rb, done);
        chk("drain_clear_write_count", 32'(nwr), 32'd35);
        chk("drain_clear_ready_low", 32'(rb), 32'd0);
        chk("drain_clear_done_seen", 32'(done), 32'd1);
        @(negedge clk);
        chk("ready_after_drain_clear", 32'(s_ready), 32'd1);
        chk("drain_scoreboard_empty", 32'(sq.size()), 32'd0);

        // reset during the 10th clear write
        for (int i = 0; i < 32; i++) sq.push_back('{19'(i), 1'b1});
        @(negedge clk); s_clr = 1'b1;
        @(negedge clk); s_clr = 1'b0;
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            @(negedge clk);
            if (s_wr_en && s_wr_addr == 5'd9) found = 1;
        end
        chk("tenth_clear_write_seen", 32'(found), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_wr_en", 32'(s_wr_en), 32'd0);
        chk("async_reset_busy", 32'(s_busy), 32'd0);
        sq.delete();
        bq.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        nwr = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (s_wr_en || b_wr_en) nwr++;
        end
        chk("no_writes_after_reset", 32'(nwr), 32'd0);
        chk("busy_after_reset", 32'(s_busy), 32'd0);
        chk("small_drop_after_reset", 32'(s_drop), 32'd0);
        chk("big_drop_after_reset", 32'(b_drop), 32'd0);
        chk("clear_done_after_reset", 32'(s_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pixel_plotter.md
# pixel_plotter

Sink end of the line-drawing coordinate stream: accepts (x, y, color) pixels from a line generator through a valid/ready handshake and converts them into framebuffer write cycles. Off-screen pixels are dropped and counted. A clear command sweeps the whole framebuffer with a background color. It sits between the line/animation logic and the VGA framebuffer RAM write port.

## Interface
- WIDTH, 640, visible columns; valid x is 0..WIDTH-1
- HEIGHT, 480, visible rows; valid y is 0..HEIGHT-1
- ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT
- COLOR_W, 1, pixel color width
- DEPTH, 4, input FIFO entries (power of two)

Ports:
- clk, input, 1: sole clock; all state on posedge clk
- reset, input, 1: asynchronous, active-high; clears all state immediately
- in_x, input, 11: pixel column
- in_y, input, 11: pixel row
- in_color, input, COLOR_W: pixel color
- in_valid, input, 1: pixel offered
- in_ready, output, 1: pixel accepted on an edge where in_valid && in_ready
- clear_req, input, 1: one-cycle request to clear the framebuffer
- bg_color, input, COLOR_W: clear color, sampled when CLEAR is entered
- wr_en, output, 1: framebuffer write strobe
- wr_addr, output, ADDR_W: write address, y*WIDTH + x
- wr_data, output, COLOR_W: write data
- clear_done, output, 1: one-cycle pulse after the last clear write
- busy, output, 1: high whenever state != IDLE
- drop_count, output, 16: wrapping count of clipped pixels

## Operation
- Input FIFO of DEPTH entries. in_ready = !full && state is IDLE or DRAW && !clear_pending.
- Accepting and popping in the same cycle is legal when the FIFO is full only if a pop occurs. in_ready still reflects full.
- The FIFO head is popped when the FIFO is non-empty and state is DRAW. The popped entry loads stage S1, which holds x, y, color and a valid bit.
- S1 computes in_range = (x < WIDTH) && (y < HEIGHT) and the address y*WIDTH + x. The address is computed at 22 bits and truncated to ADDR_W.
- The output register loads from S1:
  - wr_en = S1.valid && in_range.
  - If S1.valid && !in_range, drop_count increments by 1, wrapping at 16 bits.
- State machine:
  - IDLE -> DRAW when the FIFO is non-empty.
  - IDLE -> CLEAR on clear_req.
  - DRAW -> IDLE when the FIFO, S1 and the output register are all empty.
  - DRAW -> DRAIN on clear_req. While DRAIN, clear_pending = 1.
  - DRAIN -> CLEAR when the FIFO, S1 and the output register are all empty.
  - CLEAR -> IDLE after address WIDTH*HEIGHT-1 has been written.
  - In DRAIN, the queued pixels keep draining normally.
- CLEAR:
  - A clear address counter starts at 0 and bg_color is latched on entry.
  - wr_en = 1 every cycle, wr_addr = counter, wr_data = latched bg_color; the counter increments each cycle.
  - clear_done pulses in the cycle after the final write.
- clear_req behaviour:
  - clear_req in CLEAR or DRAIN is ignored; it does not restart or queue a second clear.
  - clear_req and in_valid in the same IDLE cycle: the clear wins and in_ready is 0 in that cycle.

## Timing
- Reset values: in_ready=0 while reset asserted, then 1 the cycle after release; wr_en=0, wr_addr=0, wr_data=0, clear_done=0, busy=0, drop_count=0. FIFO, S1, pointers and clear counter are all cleared.
- Reset mid-clear or mid-draw aborts the operation and discards all queued pixels. No further writes occur.
- Pixel latency, with the pixel accepted at edge N into an empty FIFO:
  - Edge N+1: the FIFO is non-empty and state is DRAW.
  - The pixel loads into S1 at edge N+2.
  - wr_en is high in the cycle after edge N+3.
- Throughput is one pixel per clock sustained; back-to-back accepted pixels produce back-to-back wr_en.
- Clear takes exactly WIDTH*HEIGHT consecutive wr_en cycles. clear_done follows one cycle after the last one. busy drops in the same cycle as clear_done.
- wr_en deasserts in the cycle after the last write.

## Test plan
- Reset, then offer (10,100,1), (11,100,1), (12,100,1) back-to-back:
  - wr_en for 3 consecutive cycles, first at edge N+3.
  - wr_addr = 64010, 64011, 64012; wr_data=1.
  - busy returns to 0.
- Hold the sink by offering 6 pixels in a burst with DEPTH=4: in_ready never drops, because pops keep pace with accepts. All 6 are written in order with none lost.
- Clip: offer (640,0), (0,480), (2047,2047), (5,5):
  - Only (5,5) is written, at addr 3205.
  - drop_count = 3.
- Clear with WIDTH=8, HEIGHT=4, bg_color=0:
  - 32 writes to addr 0..31 with data 0, then a clear_done pulse.
  - in_ready stays 0 throughout the clear.
- clear_req while 3 pixels are queued:
  - The 3 pixels are written first, then the 32-write clear.
  - in_ready is low from clear_req until clear_done plus 1 cycle.
- Assert reset during the 10th clear write: wr_en drops without waiting for a clock edge. After release the block is IDLE with drop_count=0 and there are no writes.
